// File: rtl/stack_seq_pkg.sv
// stack_seq_pkg: shared state/op encodings and default stack bounds for stack_sequencer
package stack_seq_pkg;
  typedef enum logic [2:0] {IDLE, PUSH, POP_RD, POP_WAIT, DONE} state_t;
  typedef enum logic [1:0] {OP_NONE, OP_CALL, OP_RET} op_t;
  localparam logic [15:0] SP_INIT_DEF  = 16'h00FF;
  localparam logic [15:0] SP_LIMIT_DEF = 16'h00FC;
endpackage

// File: rtl/stack_sequencer_sp_counter.sv
// sp_counter: stack pointer register (clk, rst, dec_i, inc_i in; sp_o, full_o at SP_LIMIT, empty_o at SP_INIT out)
module sp_counter #(
  parameter int ADDR_W = 16,
  parameter logic [ADDR_W-1:0] SP_INIT  = stack_seq_pkg::SP_INIT_DEF,
  parameter logic [ADDR_W-1:0] SP_LIMIT = stack_seq_pkg::SP_LIMIT_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              dec_i,
  input  logic              inc_i,
  output logic [ADDR_W-1:0] sp_o,
  output logic              full_o,
  output logic              empty_o
);
  logic [ADDR_W-1:0] sp_q, sp_d;
  always_comb begin
    sp_d = dec_i ? sp_q - ADDR_W'(1) : (inc_i ? sp_q + ADDR_W'(1) : sp_q);
  end
  always_ff @(posedge clk) begin
    if (rst) sp_q <= SP_INIT;
    else sp_q <= sp_d;
  end
  assign sp_o    = sp_q;
  assign full_o  = sp_q == SP_LIMIT;
  assign empty_o = sp_q == SP_INIT;
endmodule

// File: rtl/stack_sequencer.sv
// stack_sequencer: call/return stack FSM (call_req/ret_req/ret_addr/jump_target/mem_rdata/err_clr in; stall, mem_* strobes, pc_load/pc_target, sp, sticky err_ovf/err_unf out)
module stack_sequencer
  import stack_seq_pkg::*;
#(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 32,
  parameter logic [ADDR_W-1:0] SP_INIT  = SP_INIT_DEF,
  parameter logic [ADDR_W-1:0] SP_LIMIT = SP_LIMIT_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              call_req,
  input  logic              ret_req,
  input  logic [DATA_W-1:0] ret_addr,
  input  logic [DATA_W-1:0] jump_target,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              err_clr,
  output logic              stall,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_we,
  output logic              mem_re,
  output logic              pc_load,
  output logic [DATA_W-1:0] pc_target,
  output logic [ADDR_W-1:0] sp,
  output logic              err_ovf,
  output logic              err_unf
);
  state_t            state_q, state_d;
  op_t               op;
  logic              load_q, load_d;
  logic              set_ovf, set_unf, full, empty, inc;
  logic [ADDR_W-1:0] mem_addr_q;
  logic [DATA_W-1:0] mem_wdata_q, pc_target_q;
  logic              err_ovf_q, err_unf_q;
  sp_counter #(.ADDR_W(ADDR_W), .SP_INIT(SP_INIT), .SP_LIMIT(SP_LIMIT)) u_sp (
    .clk(clk), .rst(rst), .dec_i(mem_we), .inc_i(inc),
    .sp_o(sp), .full_o(full), .empty_o(empty)
  );
  always_comb begin
    op      = call_req ? OP_CALL : (ret_req ? OP_RET : OP_NONE);
    state_d = state_q;
    load_d  = load_q;
    set_ovf = 1'b0;
    set_unf = 1'b0;
    case (state_q)
      IDLE: begin
        if (op == OP_CALL) begin
          state_d = full ? DONE : PUSH;
          set_ovf = full;
          load_d  = 1'b1;
        end else if (op == OP_RET) begin
          state_d = empty ? DONE : POP_RD;
          set_unf = empty;
          load_d  = !empty;
        end
      end
      PUSH:     state_d = DONE;
      POP_RD:   state_d = POP_WAIT;
      POP_WAIT: state_d = DONE;
      default:  state_d = IDLE;
    endcase
    stall   = (state_q != IDLE && state_q != DONE) || (state_q == IDLE && op != OP_NONE);
    mem_we  = state_q == PUSH;
    mem_re  = state_q == POP_RD;
    inc     = state_q == POP_WAIT;
    pc_load = state_q == DONE && load_q;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      load_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      load_q  <= load_d;
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      pc_target_q <= '0;
      err_ovf_q   <= 1'b0;
      err_unf_q   <= 1'b0;
    end else begin
      if (state_q == IDLE && op == OP_CALL) pc_target_q <= jump_target;
      if (state_q == IDLE && op == OP_CALL && !full) begin
        mem_addr_q  <= sp - ADDR_W'(1);
        mem_wdata_q <= ret_addr;
      end
      if (state_q == IDLE && op == OP_RET && !empty) mem_addr_q <= sp;
      if (state_q == POP_WAIT) pc_target_q <= mem_rdata;
      err_ovf_q <= set_ovf | (err_ovf_q & ~err_clr);
      err_unf_q <= set_unf | (err_unf_q & ~err_clr);
    end
  end
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign pc_target = pc_target_q;
  assign err_ovf   = err_ovf_q;
  assign err_unf   = err_unf_q;
endmodule

// File: tb/tb_stack_sequencer.sv
// tb_stack_sequencer: table-driven plus directed corner-case bench for stack_sequencer
module tb_stack_sequencer;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        call_req = 1'b0, ret_req = 1'b0, err_clr = 1'b0;
  logic [31:0] ret_addr = '0, jump_target = '0, mem_rdata = '0;
  logic        stall, mem_we, mem_re, pc_load, err_ovf, err_unf;
  logic [15:0] mem_addr, sp;
  logic [31:0] mem_wdata, pc_target;
  int          checks = 0;
  int          errors = 0;
  typedef struct {
    logic         call, ret, clr;
    logic [31:0]  ra, jt, rd;
    logic [101:0] exp;
  } vec_t;
  vec_t vecs [16];
  stack_sequencer dut (
    .clk(clk), .rst(rst), .call_req(call_req), .ret_req(ret_req),
    .ret_addr(ret_addr), .jump_target(jump_target), .mem_rdata(mem_rdata),
    .err_clr(err_clr), .stall(stall), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_we(mem_we), .mem_re(mem_re), .pc_load(pc_load), .pc_target(pc_target),
    .sp(sp), .err_ovf(err_ovf), .err_unf(err_unf)
  );
  always #5 clk = ~clk;
  function automatic logic [101:0] e(input logic s, w, r, p, input logic [15:0] a,
                                     input logic [31:0] wd, tg, input logic [15:0] spv,
                                     input logic o, u);
    return {s, w, r, p, a, wd, tg, spv, o, u};
  endfunction
  function automatic logic [101:0] outs();
    return {stall, mem_we, mem_re, pc_load, mem_addr, mem_wdata, pc_target, sp, err_ovf, err_unf};
  endfunction
  task automatic chk(input string nm, input logic [101:0] act, input logic [101:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", nm, act, exp);
    end
  endtask
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask
  task automatic do_call(input logic [31:0] ra, input logic [31:0] jt);
    call_req = 1'b1; ret_addr = ra; jump_target = jt;
    cyc();
    call_req = 1'b0;
    cyc();
    cyc();
  endtask
  task automatic do_ret(input logic [31:0] rd);
    ret_req = 1'b1;
    cyc();
    ret_req = 1'b0;
    cyc();
    mem_rdata = rd;
    cyc();
    cyc();
  endtask
  initial begin
    vecs[0]  = '{0, 0, 0, 32'h00, 32'h00, 32'h00, e(0, 0, 0, 0, 16'h0000, 32'h00, 32'h00, 16'h00FF, 0, 0)};
    vecs[1]  = '{1, 0, 0, 32'h11, 32'h40, 32'h00, e(1, 0, 0, 0, 16'h0000, 32'h00, 32'h00, 16'h00FF, 0, 0)};
    vecs[2]  = '{0, 1, 0, 32'h00, 32'h00, 32'h00, e(1, 1, 0, 0, 16'h00FE, 32'h11, 32'h40, 16'h00FF, 0, 0)};
    vecs[3]  = '{0, 0, 0, 32'h00, 32'h00, 32'h00, e(0, 0, 0, 1, 16'h00FE, 32'h11, 32'h40, 16'h00FE, 0, 0)};
    vecs[4]  = '{0, 1, 0, 32'h00, 32'h00, 32'h00, e(1, 0, 0, 0, 16'h00FE, 32'h11, 32'h40, 16'h00FE, 0, 0)};
    vecs[5]  = '{0, 0, 0, 32'h00, 32'h00, 32'h00, e(1, 0, 1, 0, 16'h00FE, 32'h11, 32'h40, 16'h00FE, 0, 0)};
    vecs[6]  = '{0, 0, 0, 32'h00, 32'h00, 32'h11, e(1, 0, 0, 0, 16'h00FE, 32'h11, 32'h40, 16'h00FE, 0, 0)};
    vecs[7]  = '{0, 0, 0, 32'h00, 32'h00, 32'h00, e(0, 0, 0, 1, 16'h00FE, 32'h11, 32'h11, 16'h00FF, 0, 0)};
    vecs[8]  = '{1, 1, 0, 32'h22, 32'h50, 32'h00, e(1, 0, 0, 0, 16'h00FE, 32'h11, 32'h11, 16'h00FF, 0, 0)};
    vecs[9]  = '{0, 0, 0, 32'h00, 32'h00, 32'h00, e(1, 1, 0, 0, 16'h00FE, 32'h22, 32'h50, 16'h00FF, 0, 0)};
    vecs[10] = '{0, 0, 0, 32'h00, 32'h00, 32'h00, e(0, 0, 0, 1, 16'h00FE, 32'h22, 32'h50, 16'h00FE, 0, 0)};
    vecs[11] = '{0, 1, 0, 32'h00, 32'h00, 32'h00, e(1, 0, 0, 0, 16'h00FE, 32'h22, 32'h50, 16'h00FE, 0, 0)};
    vecs[12] = '{0, 0, 0, 32'h00, 32'h00, 32'h00, e(1, 0, 1, 0, 16'h00FE, 32'h22, 32'h50, 16'h00FE, 0, 0)};
    vecs[13] = '{0, 0, 0, 32'h00, 32'h00, 32'h22, e(1, 0, 0, 0, 16'h00FE, 32'h22, 32'h50, 16'h00FE, 0, 0)};
    vecs[14] = '{0, 0, 0, 32'h00, 32'h00, 32'h00, e(0, 0, 0, 1, 16'h00FE, 32'h22, 32'h22, 16'h00FF, 0, 0)};
    vecs[15] = '{0, 0, 0, 32'h00, 32'h00, 32'h00, e(0, 0, 0, 0, 16'h00FE, 32'h22, 32'h22, 16'h00FF, 0, 0)};
    cyc();
    cyc();
    rst = 1'b0;
    for (int i = 0; i < 16; i++) begin
      call_req = vecs[i].call; ret_req = vecs[i].ret; err_clr = vecs[i].clr;
      ret_addr = vecs[i].ra; jump_target = vecs[i].jt; mem_rdata = vecs[i].rd;
      #3;
      chk($sformatf("row%0d", i), outs(), vecs[i].exp);
      cyc();
    end
    call_req = 1'b0; ret_req = 1'b0; mem_rdata = '0;
    do_call(32'h1, 32'h2);
    do_call(32'h3, 32'h4);
    do_call(32'h5, 32'h6);
    #3;
    chk("sp_full", 102'(sp), 102'(16'h00FC));
    call_req = 1'b1; ret_addr = 32'h99; jump_target = 32'h77; err_clr = 1'b1;
    #3;
    chk("ovf_stall", 102'(stall), 102'(1'b1));
    cyc();
    call_req = 1'b0; err_clr = 1'b0;
    #3;
    chk("ovf_done", {mem_we, pc_load, err_ovf, stall, pc_target, sp, mem_wdata},
        {1'b0, 1'b1, 1'b1, 1'b0, 32'h77, 16'h00FC, 32'h5});
    cyc();
    #3;
    chk("ovf_sticky", {err_ovf, stall, pc_load}, {1'b1, 1'b0, 1'b0});
    err_clr = 1'b1;
    cyc();
    err_clr = 1'b0;
    #3;
    chk("ovf_clr", 102'(err_ovf), 102'(1'b0));
    do_ret(32'h5);
    do_ret(32'h3);
    do_ret(32'h1);
    #3;
    chk("sp_empty", {sp, pc_target}, {16'h00FF, 32'h1});
    ret_req = 1'b1;
    #3;
    chk("unf_stall", 102'(stall), 102'(1'b1));
    cyc();
    ret_req = 1'b0;
    #3;
    chk("unf_done", {mem_re, pc_load, err_unf, stall, sp}, {1'b0, 1'b0, 1'b1, 1'b0, 16'h00FF});
    cyc();
    #3;
    chk("unf_idle", {stall, mem_re, pc_load, err_unf}, {1'b0, 1'b0, 1'b0, 1'b1});
    err_clr = 1'b1;
    cyc();
    err_clr = 1'b0;
    #3;
    chk("unf_clr", 102'(err_unf), 102'(1'b0));
    do_call(32'h8, 32'h9);
    ret_req = 1'b1;
    cyc();
    ret_req = 1'b0;
    cyc();
    rst = 1'b1; mem_rdata = 32'hDEAD;
    cyc();
    rst = 1'b0;
    #3;
    chk("rst_mid", outs(), e(0, 0, 0, 0, 16'h0000, 32'h0, 32'h0, 16'h00FF, 0, 0));
    call_req = 1'b1; ret_addr = 32'hA; jump_target = 32'hB;
    cyc();
    call_req = 1'b0;
    #3;
    chk("post_rst_push", {mem_we, mem_addr, mem_wdata}, {1'b1, 16'h00FE, 32'hA});
    cyc();
    #3;
    chk("post_rst_load", {pc_load, pc_target, sp}, {1'b1, 32'hB, 16'h00FE});
    cyc();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
